// File: rtl/core_pipe_fwd_if.sv
// Observation bus of core_pipe_fwd: retire/perf-counter outputs plus a word-wide
// preload port that fills instruction and data memory (used while the core is held in reset).
interface core_pipe_fwd_if #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 ld_imem_we;
  logic                 ld_dmem_we;
  logic [7:0]           ld_addr;
  logic [DWIDTH-1:0]    ld_data;

  logic                 retire_valid;
  logic [DWIDTH-1:0]    retire_pc;
  logic                 retire_we;
  logic [4:0]           retire_rd_id;
  logic [DWIDTH-1:0]    retire_rd;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instret_cnt;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  modport slave (
    input  ld_imem_we, ld_dmem_we, ld_addr, ld_data,
    output retire_valid, retire_pc, retire_we, retire_rd_id, retire_rd,
    output cycle_cnt, instret_cnt, stall_cnt, flush_cnt
  );

  modport master (
    output ld_imem_we, ld_dmem_we, ld_addr, ld_data,
    input  retire_valid, retire_pc, retire_we, retire_rd_id, retire_rd,
    input  cycle_cnt, instret_cnt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/core_pipe_fwd.sv
// 5-stage IF/ID/EX/MEM/WB core with EX operand forwarding, load-use interlock and
// EX-resolved redirects. Word-indexed 256-entry imem/dmem; MIPS-style encoding.
module core_pipe_fwd #(
  parameter int              DWIDTH    = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0,
  parameter bit              FWD_EN    = 1'b1,
  parameter int              CNT_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  core_pipe_fwd_if.slave bus
);
  typedef logic [DWIDTH-1:0] word_t;

  localparam logic [2:0] JT_NOP = 3'd0, JT_BEQ = 3'd1, JT_JAL = 3'd2, JT_JR = 3'd3, JT_J = 3'd4;
  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3,
                         ALU_SLT = 3'd4, ALU_PASSB = 3'd5;

  word_t r_imem [256];
  word_t r_dmem [256];
  word_t r_regs [32];

  word_t r_pc;
  logic  r_id_valid;
  word_t r_id_pc, r_id_instr;
  logic  r_ex_valid, r_ex_we, r_ex_mem_rd, r_ex_mem_wr, r_ex_use_imm;
  word_t r_ex_pc, r_ex_rs_val, r_ex_rt_val, r_ex_imm;
  logic [4:0]  r_ex_rs_id, r_ex_rt_id, r_ex_rdst;
  logic [25:0] r_ex_addr;
  logic [2:0]  r_ex_alu_op, r_ex_jtype;
  logic  r_mem_valid, r_mem_we, r_mem_rd, r_mem_wr;
  word_t r_mem_pc, r_mem_alu, r_mem_sdata;
  logic [4:0] r_mem_rdst;
  logic  r_wb_valid, r_wb_we;
  word_t r_wb_pc, r_wb_data;
  logic [4:0] r_wb_rdst;
  logic [CNT_WIDTH-1:0] r_cycle_cnt, r_instret_cnt, r_stall_cnt, r_flush_cnt;

  function automatic logic dep(input logic v, input logic we, input logic [4:0] dst,
                               input logic [4:0] src);
    return v && we && (src != 5'd0) && (dst == src);
  endfunction

  // ---------------- ID: decode and regfile read ----------------
  logic [5:0] w_op, w_funct;
  logic [4:0] w_rs_id, w_rt_id, w_dec_dest, w_src_rs, w_src_rt;
  logic [2:0] w_dec_alu_op, w_dec_jtype;
  logic       w_dec_use_imm, w_dec_mem_rd, w_dec_mem_wr, w_dec_use_rs, w_dec_use_rt, w_dec_we;
  word_t      w_dec_imm, w_id_rs_val, w_id_rt_val;
  logic       w_unused;

  assign w_op     = r_id_instr[31:26];
  assign w_rs_id  = r_id_instr[25:21];
  assign w_rt_id  = r_id_instr[20:16];
  assign w_funct  = r_id_instr[5:0];
  assign w_unused = ^r_id_instr[10:6];
  assign w_dec_imm = {{(DWIDTH-16){r_id_instr[15]}}, r_id_instr[15:0]};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_dec_alu_op  = ALU_ADD;
    w_dec_jtype   = JT_NOP;
    w_dec_use_imm = 1'b0;
    w_dec_dest    = 5'd0;
    w_dec_mem_rd  = 1'b0;
    w_dec_mem_wr  = 1'b0;
    w_dec_use_rs  = 1'b1;
    w_dec_use_rt  = 1'b0;
    case (w_op)
      6'h00: begin
        w_dec_use_rt = 1'b1;
        w_dec_dest   = r_id_instr[15:11];
        case (w_funct)
          6'h22:   w_dec_alu_op = ALU_SUB;
          6'h24:   w_dec_alu_op = ALU_AND;
          6'h25:   w_dec_alu_op = ALU_OR;
          6'h2A:   w_dec_alu_op = ALU_SLT;
          6'h08: begin
            w_dec_jtype  = JT_JR;
            w_dec_use_rt = 1'b0;
            w_dec_dest   = 5'd0;
          end
          default: w_dec_alu_op = ALU_ADD;
        endcase
      end
      6'h08: begin w_dec_use_imm = 1'b1; w_dec_dest = w_rt_id; end
      6'h23: begin w_dec_use_imm = 1'b1; w_dec_dest = w_rt_id; w_dec_mem_rd = 1'b1; end
      6'h2B: begin w_dec_use_imm = 1'b1; w_dec_use_rt = 1'b1; w_dec_mem_wr = 1'b1; end
      6'h04: begin w_dec_jtype = JT_BEQ; w_dec_use_rt = 1'b1; w_dec_alu_op = ALU_SUB; end
      6'h02: begin w_dec_jtype = JT_J; w_dec_use_rs = 1'b0; end
      6'h03: begin
        w_dec_jtype  = JT_JAL;
        w_dec_use_rs = 1'b0;
        w_dec_dest   = 5'd31;
        w_dec_alu_op = ALU_PASSB;
      end
      default: w_dec_use_rs = 1'b0;
    endcase
  end

  assign w_dec_we = (w_dec_dest != 5'd0);
  assign w_src_rs = w_dec_use_rs ? w_rs_id : 5'd0;
  assign w_src_rt = w_dec_use_rt ? w_rt_id : 5'd0;

  // The retiring WB write is visible to the same-cycle ID read.
  assign w_id_rs_val = (w_rs_id == 5'd0) ? '0 :
                       dep(r_wb_valid, r_wb_we, r_wb_rdst, w_rs_id) ? r_wb_data : r_regs[w_rs_id];
  assign w_id_rt_val = (w_rt_id == 5'd0) ? '0 :
                       dep(r_wb_valid, r_wb_we, r_wb_rdst, w_rt_id) ? r_wb_data : r_regs[w_rt_id];

  // ---------------- EX: forwarding, ALU, redirect ----------------
  word_t w_dmem_rdata, w_mem_val, w_fwd_rs, w_fwd_rt, w_npc, w_alu_b, w_alu_res, w_target;
  logic  w_taken, w_redirect, w_ld_use, w_raw_any, w_stall, w_ex_go;

  assign w_dmem_rdata = r_dmem[r_mem_alu[9:2]];
  assign w_mem_val    = r_mem_rd ? w_dmem_rdata : r_mem_alu;

  always_comb begin
    w_fwd_rs = r_ex_rs_val;
    w_fwd_rt = r_ex_rt_val;
    if (FWD_EN) begin
      if (dep(r_mem_valid, r_mem_we, r_mem_rdst, r_ex_rs_id))    w_fwd_rs = w_mem_val;
      else if (dep(r_wb_valid, r_wb_we, r_wb_rdst, r_ex_rs_id))  w_fwd_rs = r_wb_data;
      if (dep(r_mem_valid, r_mem_we, r_mem_rdst, r_ex_rt_id))    w_fwd_rt = w_mem_val;
      else if (dep(r_wb_valid, r_wb_we, r_wb_rdst, r_ex_rt_id))  w_fwd_rt = r_wb_data;
    end
  end

  assign w_npc   = r_ex_pc + word_t'(4);
  assign w_alu_b = (r_ex_jtype == JT_JAL) ? w_npc : (r_ex_use_imm ? r_ex_imm : w_fwd_rt);

  always_comb begin
    case (r_ex_alu_op)
      ALU_SUB:   w_alu_res = w_fwd_rs - w_alu_b;
      ALU_AND:   w_alu_res = w_fwd_rs & w_alu_b;
      ALU_OR:    w_alu_res = w_fwd_rs | w_alu_b;
      ALU_SLT:   w_alu_res = {{(DWIDTH-1){1'b0}}, ($signed(w_fwd_rs) < $signed(w_alu_b))};
      ALU_PASSB: w_alu_res = w_alu_b;
      default:   w_alu_res = w_fwd_rs + w_alu_b;
    endcase
  end

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_npc;
    case (r_ex_jtype)
      JT_BEQ: begin w_taken = (w_fwd_rs == w_fwd_rt); w_target = w_npc + (r_ex_imm << 2); end
      JT_JAL, JT_J: begin w_taken = 1'b1; w_target = {w_npc[DWIDTH-1:DWIDTH-4], r_ex_addr, 2'b00}; end
      JT_JR:  begin w_taken = 1'b1; w_target = w_fwd_rs; end
      default: ;
    endcase
  end

  assign w_redirect = r_ex_valid & w_taken;
  assign w_ld_use   = r_ex_mem_rd & (dep(r_ex_valid, r_ex_we, r_ex_rdst, w_src_rs) |
                                     dep(r_ex_valid, r_ex_we, r_ex_rdst, w_src_rt));
  assign w_raw_any  = dep(r_ex_valid, r_ex_we, r_ex_rdst, w_src_rs)   | dep(r_ex_valid, r_ex_we, r_ex_rdst, w_src_rt) |
                      dep(r_mem_valid, r_mem_we, r_mem_rdst, w_src_rs) | dep(r_mem_valid, r_mem_we, r_mem_rdst, w_src_rt) |
                      dep(r_wb_valid, r_wb_we, r_wb_rdst, w_src_rs)    | dep(r_wb_valid, r_wb_we, r_wb_rdst, w_src_rt);
  // A redirect squashes the stalled ID instruction, so it overrides the interlock.
  assign w_stall    = r_id_valid & ~w_redirect & (FWD_EN ? w_ld_use : w_raw_any);
  assign w_ex_go    = r_id_valid & ~w_stall & ~w_redirect;

  // ---------------- Storage ----------------
  // NOTE: memory arrays carry no reset; only pipeline control and observable state is cleared.
  always_ff @(posedge clk) begin
    if (bus.ld_imem_we) r_imem[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk) begin
    if (bus.ld_dmem_we)                       r_dmem[bus.ld_addr]     <= bus.ld_data;
    else if (r_mem_valid & r_mem_wr & ~rst)   r_dmem[r_mem_alu[9:2]]  <= r_mem_sdata;
  end

  always_ff @(posedge clk) begin
    if (r_wb_valid & r_wb_we) r_regs[r_wb_rdst] <= r_wb_data;
  end

  // ---------------- Pipeline control (reset) ----------------
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_id_valid  <= 1'b0;
      r_ex_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_mem_rd <= 1'b0;
      r_ex_mem_wr <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_pc     <= '0;
      r_wb_rdst   <= 5'd0;
      r_wb_data   <= '0;
      r_cycle_cnt <= '0;
      r_instret_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_redirect) begin
        r_pc       <= w_target;
        r_id_valid <= 1'b0;
      end else if (!w_stall) begin
        r_pc       <= r_pc + word_t'(4);
        r_id_valid <= 1'b1;
      end
      r_ex_valid  <= w_ex_go;
      r_ex_we     <= w_ex_go & w_dec_we;
      r_ex_mem_rd <= w_ex_go & w_dec_mem_rd;
      r_ex_mem_wr <= w_ex_go & w_dec_mem_wr;
      r_mem_valid <= r_ex_valid;
      r_mem_we    <= r_ex_we;
      r_mem_rd    <= r_ex_mem_rd;
      r_mem_wr    <= r_ex_mem_wr;
      r_wb_valid  <= r_mem_valid;
      r_wb_we     <= r_mem_we;
      r_wb_pc     <= r_mem_pc;
      r_wb_rdst   <= r_mem_rdst;
      r_wb_data   <= w_mem_val;
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (r_wb_valid) r_instret_cnt <= r_instret_cnt + 1'b1;
      if (w_stall)    r_stall_cnt   <= r_stall_cnt + 1'b1;
      if (w_redirect) r_flush_cnt   <= r_flush_cnt + 1'b1;
    end
  end

  // ---------------- Pipeline datapath (qualified by valid bits) ----------------
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_id_pc    <= r_pc;
      r_id_instr <= r_imem[r_pc[9:2]];
    end
    r_ex_pc      <= r_id_pc;
    r_ex_rs_val  <= w_id_rs_val;
    r_ex_rt_val  <= w_id_rt_val;
    r_ex_imm     <= w_dec_imm;
    r_ex_rs_id   <= w_src_rs;
    r_ex_rt_id   <= w_src_rt;
    r_ex_rdst    <= w_dec_dest;
    r_ex_addr    <= r_id_instr[25:0];
    r_ex_alu_op  <= w_dec_alu_op;
    r_ex_jtype   <= w_dec_jtype;
    r_ex_use_imm <= w_dec_use_imm;
    r_mem_pc     <= r_ex_pc;
    r_mem_alu    <= w_alu_res;
    r_mem_sdata  <= w_fwd_rt;
    r_mem_rdst   <= r_ex_rdst;
  end

  assign bus.retire_valid = r_wb_valid;
  assign bus.retire_pc    = r_wb_pc;
  assign bus.retire_we    = r_wb_we;
  assign bus.retire_rd_id = r_wb_rdst;
  assign bus.retire_rd    = r_wb_data;
  assign bus.cycle_cnt    = r_cycle_cnt;
  assign bus.instret_cnt  = r_instret_cnt;
  assign bus.stall_cnt    = r_stall_cnt;
  assign bus.flush_cnt    = r_flush_cnt;
endmodule

// File: tb/tb_core_pipe_fwd.sv
// Directed bench for core_pipe_fwd: a forwarding core and a full-interlock core run the same
// programs; retire bus and counters are compared against hand-computed values.
module tb_core_pipe_fwd;
  logic        clk = 1'b0;
  logic        rst;
  logic        ld_imem_we, ld_dmem_we;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] prog [32];
  logic [31:0] dm   [4];
  int          cyc;
  int          n_checks = 0;
  int          n_fail   = 0;

  core_pipe_fwd_if #(.DWIDTH(32), .CNT_WIDTH(32)) ifc_f ();
  core_pipe_fwd_if #(.DWIDTH(32), .CNT_WIDTH(32)) ifc_n ();

  assign ifc_f.ld_imem_we = ld_imem_we;
  assign ifc_f.ld_dmem_we = ld_dmem_we;
  assign ifc_f.ld_addr    = ld_addr;
  assign ifc_f.ld_data    = ld_data;
  assign ifc_n.ld_imem_we = ld_imem_we;
  assign ifc_n.ld_dmem_we = ld_dmem_we;
  assign ifc_n.ld_addr    = ld_addr;
  assign ifc_n.ld_data    = ld_data;

  core_pipe_fwd #(.DWIDTH(32), .RESET_PC(32'h0), .FWD_EN(1'b1), .CNT_WIDTH(32))
    u_fwd   (.clk(clk), .rst(rst), .bus(ifc_f));
  core_pipe_fwd #(.DWIDTH(32), .RESET_PC(32'h0), .FWD_EN(1'b0), .CNT_WIDTH(32))
    u_nofwd (.clk(clk), .rst(rst), .bus(ifc_n));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] addr);
    return {op, addr};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
  endtask

  // Holds reset while preloading imem (and optionally dmem) through the load port.
  task automatic load_and_hold(input bit load_dm);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ld_imem_we = 1'b1; ld_dmem_we = 1'b0; ld_addr = 8'(i); ld_data = prog[i];
    end
    if (load_dm) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        ld_imem_we = 1'b0; ld_dmem_we = 1'b1; ld_addr = 8'(i); ld_data = dm[i];
      end
    end
    @(negedge clk);
    ld_imem_we = 1'b0; ld_dmem_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic tick_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ld_imem_we = 1'b0; ld_dmem_we = 1'b0; ld_addr = 8'd0; ld_data = 32'd0; cyc = 0;
    dm[0] = 32'h1234; dm[1] = 32'hAAAA; dm[2] = 32'h0; dm[3] = 32'h0;

    // 1/4: addi r1,r0,5 ; add r2,r1,r1 -- forwarding core and full-interlock core
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    prog[1] = enc_r(5'd2, 5'd1, 5'd1, 6'h20);
    load_and_hold(1'b1);
    release_rst();
    check("t1_c0_retire_valid", 32'(ifc_f.retire_valid), 32'd0);
    check("t1_c0_cycle_cnt",    ifc_f.cycle_cnt,         32'd0);
    check("t1_c0_instret_cnt",  ifc_f.instret_cnt,       32'd0);
    check("t1_c0_flush_cnt",    ifc_f.flush_cnt,         32'd0);
    tick_to(4);
    check("t1_c4_retire_valid", 32'(ifc_f.retire_valid), 32'd1);
    check("t1_c4_retire_pc",    ifc_f.retire_pc,         32'h0);
    check("t1_c4_retire_rd",    ifc_f.retire_rd,         32'd5);
    check("t1_c4_retire_we",    32'(ifc_f.retire_we),    32'd1);
    check("t1_c4_cycle_cnt",    ifc_f.cycle_cnt,         32'd4);
    tick_to(5);
    check("t1_c5_retire_valid", 32'(ifc_f.retire_valid), 32'd1);
    check("t1_c5_retire_pc",    ifc_f.retire_pc,         32'h4);
    check("t1_c5_retire_rd_id", 32'(ifc_f.retire_rd_id), 32'd2);
    check("t1_c5_retire_rd",    ifc_f.retire_rd,         32'd10);
    check("t1_c5_stall_cnt",    ifc_f.stall_cnt,         32'd0);
    tick_to(8);
    check("t4_c8_retire_pc",    ifc_n.retire_pc,         32'h4);
    check("t4_c8_retire_rd",    ifc_n.retire_rd,         32'd10);
    check("t4_c8_stall_cnt",    ifc_n.stall_cnt,         32'd3);
    check("t1_c8_instret_cnt",  ifc_f.instret_cnt,       32'd4);

    // 2: lw r3,0(r0) ; add r4,r3,r3 -- one load-use bubble
    clear_prog();
    prog[0] = enc_i(6'h23, 5'd3, 5'd0, 16'd0);
    prog[1] = enc_r(5'd4, 5'd3, 5'd3, 6'h20);
    load_and_hold(1'b1);
    release_rst();
    tick_to(4);
    check("t2_c4_retire_rd",    ifc_f.retire_rd,         32'h1234);
    tick_to(5);
    check("t2_c5_bubble",       32'(ifc_f.retire_valid), 32'd0);
    tick_to(6);
    check("t2_c6_retire_pc",    ifc_f.retire_pc,         32'h4);
    check("t2_c6_retire_rd",    ifc_f.retire_rd,         32'h2468);
    check("t2_c6_stall_cnt",    ifc_f.stall_cnt,         32'd1);

    // 3: beq r0,r0,+2 squashes the next two addi
    clear_prog();
    prog[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
    prog[1] = enc_i(6'h08, 5'd5, 5'd0, 16'd1);
    prog[2] = enc_i(6'h08, 5'd6, 5'd0, 16'd2);
    prog[3] = enc_i(6'h08, 5'd7, 5'd0, 16'd3);
    load_and_hold(1'b1);
    release_rst();
    tick_to(4);
    check("t3_c4_beq_valid",    32'(ifc_f.retire_valid), 32'd1);
    check("t3_c4_beq_we",       32'(ifc_f.retire_we),    32'd0);
    tick_to(5);
    check("t3_c5_squashed",     32'(ifc_f.retire_valid), 32'd0);
    tick_to(6);
    check("t3_c6_squashed",     32'(ifc_f.retire_valid), 32'd0);
    tick_to(7);
    check("t3_c7_retire_pc",    ifc_f.retire_pc,         32'hC);
    check("t3_c7_retire_rd_id", 32'(ifc_f.retire_rd_id), 32'd7);
    check("t3_c7_flush_cnt",    ifc_f.flush_cnt,         32'd1);
    check("t3_c7_stall_cnt",    ifc_f.stall_cnt,         32'd0);

    // 5: jal 0x40 at 0x10, jr r31 at 0x40, return to 0x14
    clear_prog();
    prog[4]  = enc_j(6'h03, 26'h10);
    prog[5]  = enc_i(6'h08, 5'd5, 5'd0, 16'd9);
    prog[16] = enc_r(5'd0, 5'd31, 5'd0, 6'h08);
    load_and_hold(1'b1);
    release_rst();
    tick_to(8);
    check("t5_c8_jal_pc",       ifc_f.retire_pc,         32'h10);
    check("t5_c8_jal_rd_id",    32'(ifc_f.retire_rd_id), 32'd31);
    check("t5_c8_jal_rd",       ifc_f.retire_rd,         32'h14);
    tick_to(10);
    check("t5_c10_squashed",    32'(ifc_f.retire_valid), 32'd0);
    tick_to(11);
    check("t5_c11_target_pc",   ifc_f.retire_pc,         32'h40);
    tick_to(14);
    check("t5_c14_return_pc",   ifc_f.retire_pc,         32'h14);
    check("t5_c14_return_rd",   ifc_f.retire_rd,         32'd9);
    check("t5_c14_flush_cnt",   ifc_f.flush_cnt,         32'd2);

    // 6: reset while sw r1,4(r0) is in MEM; dmem[1] must keep its preload
    clear_prog();
    prog[0] = enc_i(6'h08, 5'd1, 5'd0, 16'h55);
    prog[1] = enc_i(6'h2B, 5'd1, 5'd0, 16'd4);
    load_and_hold(1'b1);
    release_rst();
    tick_to(4);
    check("t6_c4_addi_rd",      ifc_f.retire_rd,         32'h55);
    rst = 1'b1;
    clear_prog();
    prog[0] = enc_i(6'h23, 5'd2, 5'd0, 16'd4);
    load_and_hold(1'b0);
    check("t6_rst_retire_valid", 32'(ifc_f.retire_valid), 32'd0);
    check("t6_rst_cycle_cnt",   ifc_f.cycle_cnt,         32'd0);
    check("t6_rst_instret_cnt", ifc_f.instret_cnt,       32'd0);
    check("t6_rst_flush_cnt",   ifc_f.flush_cnt,         32'd0);
    release_rst();
    tick_to(4);
    check("t6_c4_first_pc",     ifc_f.retire_pc,         32'h0);
    check("t6_c4_mem_kept",     ifc_f.retire_rd,         32'hAAAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
